// File: rtl/srl_udl_pair_if.sv
// Bus bundle for srl_udl_pair: delay-line serial I/O plus counter control and value.
// The master side is the trigger logic driving the primitive; the slave side is the primitive itself.
interface srl_udl_pair_if #(
  parameter int WIDTH = 2
) ();

  logic             SRL_CE;
  logic             SRL_I;
  logic             SRL_O;
  logic             CNT_CE;
  logic             CNT_L;
  logic             CNT_UP;
  logic [WIDTH-1:0] CNT_D;
  logic [WIDTH-1:0] CNT_Q;

  modport master (
    output SRL_CE,
    output SRL_I,
    output CNT_CE,
    output CNT_L,
    output CNT_UP,
    output CNT_D,
    input  SRL_O,
    input  CNT_Q
  );

  modport slave (
    input  SRL_CE,
    input  SRL_I,
    input  CNT_CE,
    input  CNT_L,
    input  CNT_UP,
    input  CNT_D,
    output SRL_O,
    output CNT_Q
  );

endinterface

// File: rtl/srl_udl_pair.sv
// Paired trigger primitive: a clock-enabled shift-register delay line and an up/down
// counter with synchronous load, optionally triplicated with majority voting.
module srl_udl_pair #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 2,
  parameter int TMR   = 0
) (
  input  logic          CLK,
  input  logic          RST,
  srl_udl_pair_if.slave bus
);

  // The delay line is deliberately reset-free so it can map onto SRL/LUT-RAM.
  logic [DEPTH-1:0] srl_q = '0;
  logic [DEPTH-1:0] srl_d;

  if (DEPTH == 1) begin : g_srl_single
    always_comb begin
      srl_d = srl_q;
      if (bus.SRL_CE) begin
        srl_d = bus.SRL_I;
      end
    end
  end else begin : g_srl_chain
    always_comb begin
      srl_d = srl_q;
      if (bus.SRL_CE) begin
        srl_d = {srl_q[DEPTH-2:0], bus.SRL_I};
      end
    end
  end

  always_ff @(posedge CLK) begin
    srl_q <= srl_d;
  end

  assign bus.SRL_O = srl_q[DEPTH-1];

  // Next state is always derived from the voted value so a single upset copy is scrubbed.
  logic [WIDTH-1:0] cnt_vote;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_vote;
    if (bus.CNT_L) begin
      cnt_d = bus.CNT_D;
    end else if (bus.CNT_CE) begin
      if (bus.CNT_UP) begin
        cnt_d = cnt_vote + WIDTH'(1);
      end else begin
        cnt_d = cnt_vote - WIDTH'(1);
      end
    end
  end

  if (TMR != 0) begin : g_tmr
    (* keep = "true", dont_touch = "true", equivalent_register_removal = "no" *)
    logic [WIDTH-1:0] cnt0_q = '0;
    (* keep = "true", dont_touch = "true", equivalent_register_removal = "no" *)
    logic [WIDTH-1:0] cnt1_q = '0;
    (* keep = "true", dont_touch = "true", equivalent_register_removal = "no" *)
    logic [WIDTH-1:0] cnt2_q = '0;

    always_ff @(posedge CLK) begin
      if (RST) begin
        cnt0_q <= '0;
        cnt1_q <= '0;
        cnt2_q <= '0;
      end else begin
        cnt0_q <= cnt_d;
        cnt1_q <= cnt_d;
        cnt2_q <= cnt_d;
      end
    end

    assign cnt_vote = (cnt0_q & cnt1_q) | (cnt0_q & cnt2_q) | (cnt1_q & cnt2_q);
  end else begin : g_single
    logic [WIDTH-1:0] cnt_q = '0;

    always_ff @(posedge CLK) begin
      if (RST) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_vote = cnt_q;
  end

  assign bus.CNT_Q = cnt_vote;

endmodule

// File: tb/tb_srl_udl_pair.sv
// Bench for srl_udl_pair: three instances (DEPTH 16/432/1, TMR off/on) checked every
// cycle against a queue-based delay model and an arithmetic counter model.
module tb_srl_udl_pair;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  srl_udl_pair_if #(.WIDTH(2)) if_a ();
  srl_udl_pair_if #(.WIDTH(2)) if_b ();
  srl_udl_pair_if #(.WIDTH(5)) if_c ();

  srl_udl_pair #(.DEPTH(16),  .WIDTH(2), .TMR(0)) u_a (.CLK(clk), .RST(rst), .bus(if_a));
  srl_udl_pair #(.DEPTH(432), .WIDTH(2), .TMR(1)) u_b (.CLK(clk), .RST(rst), .bus(if_b));
  srl_udl_pair #(.DEPTH(1),   .WIDTH(5), .TMR(0)) u_c (.CLK(clk), .RST(rst), .bus(if_c));

  logic       srl_ce_a = 1'b0, srl_i_a = 1'b0;
  logic       srl_ce_b = 1'b0, srl_i_b = 1'b0;
  logic       srl_ce_c = 1'b0, srl_i_c = 1'b0;
  logic       cnt_ce = 1'b0, cnt_l = 1'b0, cnt_up = 1'b0;
  logic [4:0] cnt_d = '0;

  assign if_a.SRL_CE = srl_ce_a;
  assign if_a.SRL_I  = srl_i_a;
  assign if_b.SRL_CE = srl_ce_b;
  assign if_b.SRL_I  = srl_i_b;
  assign if_c.SRL_CE = srl_ce_c;
  assign if_c.SRL_I  = srl_i_c;
  assign if_a.CNT_CE = cnt_ce;
  assign if_b.CNT_CE = cnt_ce;
  assign if_c.CNT_CE = cnt_ce;
  assign if_a.CNT_L  = cnt_l;
  assign if_b.CNT_L  = cnt_l;
  assign if_c.CNT_L  = cnt_l;
  assign if_a.CNT_UP = cnt_up;
  assign if_b.CNT_UP = cnt_up;
  assign if_c.CNT_UP = cnt_up;
  assign if_a.CNT_D  = cnt_d[1:0];
  assign if_b.CNT_D  = cnt_d[1:0];
  assign if_c.CNT_D  = cnt_d;

  int assert_count = 0;
  int fail_count   = 0;
  bit compare_on   = 1'b0;

  // Model state: every bit accepted on an enabled edge, and the counter as an integer.
  bit          hist_a[$];
  bit          hist_b[$];
  bit          hist_c[$];
  int unsigned m_cnt_a = 0;
  int unsigned m_cnt_b = 0;
  int unsigned m_cnt_c = 0;

  function automatic int unsigned cnt_next(input int unsigned q, input int width);
    int unsigned mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    if (rst)    return 0;
    if (cnt_l)  return 32'(cnt_d) & mask;
    if (cnt_ce) return cnt_up ? ((q + 1) & mask) : ((q - 1) & mask);
    return q;
  endfunction

  function automatic bit exp_a();
    return (hist_a.size() >= 16) ? hist_a[hist_a.size() - 16] : 1'b0;
  endfunction

  function automatic bit exp_b();
    return (hist_b.size() >= 432) ? hist_b[hist_b.size() - 432] : 1'b0;
  endfunction

  function automatic bit exp_c();
    return (hist_c.size() >= 1) ? hist_c[hist_c.size() - 1] : 1'b0;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    assert_count++;
    if (actual != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock: inputs are already set, the model absorbs the edge, then return at negedge.
  task automatic applyStimulus();
    @(posedge clk);
    if (srl_ce_a) hist_a.push_back(srl_i_a);
    if (srl_ce_b) hist_b.push_back(srl_i_b);
    if (srl_ce_c) hist_c.push_back(srl_i_c);
    m_cnt_a = cnt_next(m_cnt_a, 2);
    m_cnt_b = cnt_next(m_cnt_b, 2);
    m_cnt_c = cnt_next(m_cnt_c, 5);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (compare_on) begin
      checkOutput("srl_o_a", if_a.SRL_O, exp_a());
      checkOutput("srl_o_b", if_b.SRL_O, exp_b());
      checkOutput("srl_o_c", if_c.SRL_O, exp_c());
      checkOutput("cnt_q_a", if_a.CNT_Q, m_cnt_a);
      checkOutput("cnt_q_b", if_b.CNT_Q, m_cnt_b);
      checkOutput("cnt_q_c", if_c.CNT_Q, m_cnt_c);
    end
  end

  initial begin
    int exp_up[5];
    int exp_dn[2];
    int pat[4];
    int high_cnt;
    int first_high;
    exp_up = '{1, 2, 3, 0, 1};
    exp_dn = '{0, 3};
    pat    = '{1, 0, 1, 1};

    compare_on = 1'b1;

    // Reset with the delay lines idle.
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("reset_cnt_a", if_a.CNT_Q, 0);
    checkOutput("reset_cnt_b", if_b.CNT_Q, 0);
    checkOutput("reset_srl_a", if_a.SRL_O, 0);

    // Count up five, then down two.
    rst = 1'b0; cnt_ce = 1'b1; cnt_up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("up_seq_a", if_a.CNT_Q, exp_up[i]);
      checkOutput("up_seq_b", if_b.CNT_Q, exp_up[i]);
    end
    checkOutput("up_seq_c", if_c.CNT_Q, 5);
    cnt_up = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      checkOutput("dn_seq_a", if_a.CNT_Q, exp_dn[i]);
      checkOutput("dn_seq_b", if_b.CNT_Q, exp_dn[i]);
    end

    // Load beats count, then hold.
    cnt_l = 1'b1; cnt_d = 5'd2; cnt_up = 1'b1;
    applyStimulus();
    checkOutput("load_wins_a", if_a.CNT_Q, 2);
    checkOutput("load_wins_b", if_b.CNT_Q, 2);
    cnt_l = 1'b0; cnt_ce = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("hold_a", if_a.CNT_Q, 2);
    checkOutput("hold_c", if_c.CNT_Q, 2);

    // Reset beats load; first edge after release loads normally.
    rst = 1'b1; cnt_l = 1'b1; cnt_d = 5'd3; cnt_ce = 1'b1;
    applyStimulus();
    checkOutput("reset_wins_a", if_a.CNT_Q, 0);
    checkOutput("reset_wins_b", if_b.CNT_Q, 0);
    rst = 1'b0;
    applyStimulus();
    checkOutput("load_after_rst_b", if_b.CNT_Q, 3);
    checkOutput("load_after_rst_c", if_c.CNT_Q, 3);

    // Down-count wrap from zero.
    rst = 1'b1; cnt_l = 1'b0;
    applyStimulus();
    rst = 1'b0; cnt_ce = 1'b1; cnt_up = 1'b0;
    applyStimulus();
    checkOutput("wrap_dn_a", if_a.CNT_Q, 3);
    checkOutput("wrap_dn_c", if_c.CNT_Q, 31);

    // Overlap usage: A feeds the 16-deep line, B is its output, counter tracks A xor B.
    rst = 1'b1; cnt_ce = 1'b0;
    applyStimulus();
    rst = 1'b0;
    srl_ce_a = 1'b1; srl_ce_c = 1'b1;
    for (int t = 0; t < 30; t++) begin
      srl_i_a = (t == 0 || t == 4 || t == 8);
      srl_i_c = srl_i_a;
      cnt_ce  = srl_i_a ^ if_a.SRL_O;
      cnt_up  = srl_i_a;
      applyStimulus();
      checkOutput("pulse16_a", if_a.SRL_O, (t == 15 || t == 19 || t == 23) ? 1 : 0);
      if (t == 0) checkOutput("depth1_c", if_c.SRL_O, 1);
      if (t == 1) checkOutput("depth1_c_end", if_c.SRL_O, 0);
      if (t == 8) checkOutput("overlap_peak_a", if_a.CNT_Q, 3);
    end
    checkOutput("overlap_end_a", if_a.CNT_Q, 0);
    cnt_ce = 1'b0; srl_i_c = 1'b0;

    // Pattern 1,0,1,1 emerges intact 16 edges later.
    for (int t = 0; t < 24; t++) begin
      srl_i_a = (t < 4) ? pat[t][0] : 1'b0;
      applyStimulus();
      checkOutput("pattern_a", if_a.SRL_O, (t >= 15 && t <= 18) ? pat[t - 15] : 0);
    end
    srl_i_a = 1'b0;

    // 432-deep line with CE every other cycle, reset pulsed mid-flight, counter busy too.
    high_cnt   = 0;
    first_high = -1;
    for (int t = 0; t < 900; t++) begin
      srl_ce_b = (t % 2 == 0);
      srl_i_b  = (t == 0);
      srl_ce_c = (t % 5 != 4);
      srl_i_c  = (t % 3 == 0);
      rst      = (t >= 400 && t < 403);
      cnt_ce   = (t % 7 != 0);
      cnt_up   = (t % 11 < 6);
      cnt_l    = (t % 50 == 25);
      cnt_d    = 5'(t);
      applyStimulus();
      if (if_b.SRL_O) begin
        high_cnt++;
        if (first_high < 0) first_high = t;
      end
    end
    checkOutput("pulse432_width", high_cnt, 2);
    checkOutput("pulse432_start", first_high, 862);

    compare_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
